// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and constants for the multi-cycle main control FSM
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JSPAL = 6'b010011;
  localparam logic [5:0] OP_BALRZ = 6'b010100;

  localparam logic [2:0] BJ_NONE  = 3'b000;
  localparam logic [2:0] BJ_BEQ   = 3'b001;
  localparam logic [2:0] BJ_BNE   = 3'b010;
  localparam logic [2:0] BJ_JSPAL = 3'b011;
  localparam logic [2:0] BJ_BALRZ = 3'b100;
  localparam logic [2:0] BJ_J     = 3'b101;

  // ALU operand B: register B, constant 4, sign-extended immediate, branch target offset
  localparam logic [1:0] ASB_REG  = 2'b00;
  localparam logic [1:0] ASB_FOUR = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_BTGT = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       irwrite;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [2:0] bj;
    logic       illegal;
    logic       busy;
  } ctrl_t;

  function automatic logic [2:0] bj_code(input logic [5:0] op);
    logic [2:0] code;
    case (op)
      OP_BEQ:   code = BJ_BEQ;
      OP_BNE:   code = BJ_BNE;
      OP_JSPAL: code = BJ_JSPAL;
      OP_BALRZ: code = BJ_BALRZ;
      OP_J:     code = BJ_J;
      default:  code = BJ_NONE;
    endcase
    return code;
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JSPAL, OP_BALRZ};
  endfunction

endpackage

// File: rtl/mcctrl_dec.sv
// rtl/mcctrl_dec.sv - combinational state-to-strobe decoder for mcctrl
module mcctrl_dec
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] op,
  input  logic       mem_rdy,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    ctrl.busy = (state != S_IDLE);
    case (state)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b0;
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = ASB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        // IR and PC load only on the completing cycle, so each fires once per instruction
        ctrl.irwrite = mem_rdy;
        ctrl.pcwrite = mem_rdy;
      end
      S_DECODE: begin
        ctrl.alusrcb = ASB_BTGT;
        ctrl.illegal = !op_known(op);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ASB_IMM;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.regdst   = 1'b0;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ASB_REG;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        ctrl.memtoreg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = ASB_REG;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.bj          = bj_code(op);
      end
      S_JUMP: begin
        ctrl.pcwritecond = 1'b1;
        ctrl.bj          = bj_code(op);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mcctrl.sv
// rtl/mcctrl.sv - multi-cycle main control FSM with shared-memory ready handshake
module mcctrl
  import mc_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] op,
  input  logic           mem_rdy,
  output logic           pcwrite,
  output logic           pcwritecond,
  output logic           irwrite,
  output logic           iord,
  output logic           memread,
  output logic           memwrite,
  output logic           regwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     aluop,
  output logic [2:0]     bj,
  output logic           illegal,
  output logic           busy
);

  state_e     state_q, state_d;
  logic [5:0] op6;
  ctrl_t      ctrl;

  assign op6 = 6'(op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op6)
          OP_LW, OP_SW:               state_d = S_MEMADR;
          OP_RTYPE:                   state_d = S_EXEC;
          OP_BEQ, OP_BNE, OP_BALRZ:   state_d = S_BRANCH;
          OP_J, OP_JSPAL:             state_d = S_JUMP;
          // PC was already incremented in FETCH, so simply move on
          default:                    state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op6 == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  mcctrl_dec u_dec (
    .state   (state_q),
    .op      (op6),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  always_comb begin
    pcwrite     = ctrl.pcwrite;
    pcwritecond = ctrl.pcwritecond;
    irwrite     = ctrl.irwrite;
    iord        = ctrl.iord;
    memread     = ctrl.memread;
    memwrite    = ctrl.memwrite;
    regwrite    = ctrl.regwrite;
    regdst      = ctrl.regdst;
    memtoreg    = ctrl.memtoreg;
    alusrca     = ctrl.alusrca;
    alusrcb     = ctrl.alusrcb;
    aluop       = ctrl.aluop;
    bj          = ctrl.bj;
    illegal     = ctrl.illegal;
    busy        = ctrl.busy;
  end

endmodule

// File: tb/tb_mcctrl.sv
// tb/tb_mcctrl.sv - directed self-checking bench for mcctrl
module tb_mcctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       mem_rdy;
  logic       pcwrite, pcwritecond, irwrite, iord, memread, memwrite;
  logic       regwrite, regdst, memtoreg, alusrca, illegal, busy;
  logic [1:0] alusrcb, aluop;
  logic [2:0] bj;
  logic [18:0] outs;

  int errors = 0;
  int checks = 0;

  mcctrl #(.OPW(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .mem_rdy     (mem_rdy),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .irwrite     (irwrite),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .regwrite    (regwrite),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .bj          (bj),
    .illegal     (illegal),
    .busy        (busy)
  );

  assign outs = {pcwrite, pcwritecond, irwrite, iord, memread, memwrite, regwrite,
                 regdst, memtoreg, alusrca, alusrcb, aluop, bj, illegal, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic pcw, pcwc, irw, ird, mr, mw, rw, rd, m2r, asa,
                                     input logic [1:0] asb, aop, input logic [2:0] bjc,
                                     input logic ill, bsy);
    return {pcw, pcwc, irw, ird, mr, mw, rw, rd, m2r, asa, asb, aop, bjc, ill, bsy};
  endfunction

  function automatic logic [18:0] v_idle();
    return '0;
  endfunction
  function automatic logic [18:0] v_fetch(input logic rdy);
    return mk(rdy, 0, rdy, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0, 1);
  endfunction
  function automatic logic [18:0] v_decode(input logic ill);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b000, ill, 1);
  endfunction
  function automatic logic [18:0] v_memadr();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, 0, 1);
  endfunction
  function automatic logic [18:0] v_memrd();
    return mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 1);
  endfunction
  function automatic logic [18:0] v_memwb();
    return mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0, 1);
  endfunction
  function automatic logic [18:0] v_memwr();
    return mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 1);
  endfunction
  function automatic logic [18:0] v_exec();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 3'b000, 0, 1);
  endfunction
  function automatic logic [18:0] v_aluwb();
    return mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 0, 1);
  endfunction
  function automatic logic [18:0] v_branch(input logic [2:0] bjc);
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, bjc, 0, 1);
  endfunction
  function automatic logic [18:0] v_jump(input logic [2:0] bjc);
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, bjc, 0, 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called on a falling edge: drive mem_rdy, sample, then advance one clock.
  task automatic step(input string tag, input logic rdy, input logic [18:0] exp);
    mem_rdy = rdy;
    #1;
    check(tag, 32'(outs), 32'(exp));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic branch_instr(input string tag, input logic [5:0] opc, input logic is_jump,
                              input logic [2:0] bjc);
    op = opc;
    step({tag, "_fetch"}, 1'b1, v_fetch(1'b1));
    step({tag, "_decode"}, 1'b1, v_decode(1'b0));
    step({tag, "_pcw"}, 1'b1, is_jump ? v_jump(bjc) : v_branch(bjc));
  endtask

  initial begin
    rst = 1'b1;
    op = 6'b000000;
    mem_rdy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_outs", 32'(outs), 32'(v_idle()));
    rst = 1'b0;
    step("idle_after_release", 1'b1, v_idle());

    op = 6'b000000;
    step("rtype_c1_fetch", 1'b1, v_fetch(1'b1));
    step("rtype_c2_decode", 1'b1, v_decode(1'b0));
    step("rtype_c3_exec", 1'b1, v_exec());
    step("rtype_c4_aluwb", 1'b1, v_aluwb());

    op = 6'b100011;
    step("lw_fetch_wait1", 1'b0, v_fetch(1'b0));
    step("lw_fetch_wait2", 1'b0, v_fetch(1'b0));
    step("lw_fetch_rdy", 1'b1, v_fetch(1'b1));
    step("lw_decode", 1'b1, v_decode(1'b0));
    step("lw_memadr", 1'b1, v_memadr());
    step("lw_memrd_wait", 1'b0, v_memrd());
    step("lw_memrd_rdy", 1'b1, v_memrd());
    step("lw_memwb", 1'b1, v_memwb());

    op = 6'b101011;
    step("sw_fetch", 1'b1, v_fetch(1'b1));
    step("sw_decode", 1'b1, v_decode(1'b0));
    step("sw_memadr", 1'b1, v_memadr());
    step("sw_memwr", 1'b1, v_memwr());

    branch_instr("beq", 6'b000100, 1'b0, 3'b001);
    branch_instr("bne", 6'b000101, 1'b0, 3'b010);
    branch_instr("balrz", 6'b010100, 1'b0, 3'b100);
    branch_instr("jspal", 6'b010011, 1'b1, 3'b011);
    branch_instr("j", 6'b000010, 1'b1, 3'b101);

    op = 6'b111111;
    step("ill_fetch", 1'b1, v_fetch(1'b1));
    step("ill_decode", 1'b1, v_decode(1'b1));

    op = 6'b101011;
    step("ill_next_fetch", 1'b1, v_fetch(1'b1));
    step("sw2_decode", 1'b1, v_decode(1'b0));
    step("sw2_memadr", 1'b1, v_memadr());
    step("sw2_memwr_wait1", 1'b0, v_memwr());
    step("sw2_memwr_wait2", 1'b0, v_memwr());
    step("sw2_memwr_rdy", 1'b1, v_memwr());

    op = 6'b100011;
    step("rstlw_fetch", 1'b1, v_fetch(1'b1));
    step("rstlw_decode", 1'b1, v_decode(1'b0));
    step("rstlw_memadr", 1'b1, v_memadr());
    mem_rdy = 1'b0;
    #1;
    check("rstlw_memrd", 32'(outs), 32'(v_memrd()));
    rst = 1'b1;
    #1;
    check("rst_async_outs", 32'(outs), 32'(v_idle()));
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_held_outs", 32'(outs), 32'(v_idle()));
    check("rst_no_memwrite", 32'(memwrite), 32'd0);
    rst = 1'b0;
    step("rst_release_idle", 1'b0, v_idle());
    step("rst_first_fetch", 1'b0, v_fetch(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
